// File: rtl/iob_soc_opencryptolinux_boot_copier_pkg.sv
// Shared definitions for the boot copier: FSM state encoding and counter sizing.
// Kept as plain constants so older code that compares raw state values still works.
package iob_soc_opencryptolinux_boot_copier_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] COPY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter must be able to hold COPY_WORDS itself, hence the +1.
    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/iob_soc_opencryptolinux_dport_mux.sv
// Selects who drives the SRAM data port: the boot copier while copying,
// the CPU data bus once the copy is done.
module iob_soc_opencryptolinux_dport_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
) (
    input  logic                sel_cpu,
    input  logic                copy_valid,
    input  logic [ADDR_W-1:0]   copy_addr,
    input  logic [DATA_W-1:0]   copy_wdata,
    input  logic [DATA_W/8-1:0] copy_wstrb,
    input  logic                cpu_valid,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic                ram_valid,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wstrb
);

    assign ram_valid = sel_cpu ? cpu_valid : copy_valid;
    assign ram_addr  = sel_cpu ? cpu_addr  : copy_addr;
    assign ram_wdata = sel_cpu ? cpu_wdata : copy_wdata;
    assign ram_wstrb = sel_cpu ? cpu_wstrb : copy_wstrb;

endmodule

// File: rtl/iob_soc_opencryptolinux_boot_copier.sv
// Boot preloader: holds the CPU in reset while streaming the boot ROM into SRAM
// one word per cycle, then hands the SRAM data port over to the CPU.
module iob_soc_opencryptolinux_boot_copier
    import iob_soc_opencryptolinux_boot_copier_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BOOTROM_ADDR_W = 12,
    parameter int SRAM_ADDR_W    = 15,
    parameter int COPY_WORDS     = 2 ** (BOOTROM_ADDR_W - 2),
    parameter int DEST_BASE      = 2 ** (SRAM_ADDR_W - 2) - COPY_WORDS
) (
    input  logic                        clk_i,
    input  logic                        cke_i,
    input  logic                        arst_n_i,
    input  logic                        start_i,
    output logic                        cpu_rst_o,
    output logic                        done_o,
    output logic                        busy_o,
    output logic                        rom_r_valid_o,
    output logic [BOOTROM_ADDR_W-3:0]   rom_r_addr_o,
    input  logic [DATA_W-1:0]           rom_r_rdata_i,
    input  logic                        cpu_d_valid_i,
    input  logic [SRAM_ADDR_W-3:0]      cpu_d_addr_i,
    input  logic [DATA_W-1:0]           cpu_d_wdata_i,
    input  logic [DATA_W/8-1:0]         cpu_d_wstrb_i,
    output logic [DATA_W-1:0]           cpu_d_rdata_o,
    output logic                        ram_d_valid_o,
    output logic [SRAM_ADDR_W-3:0]      ram_d_addr_o,
    output logic [DATA_W-1:0]           ram_d_wdata_o,
    output logic [DATA_W/8-1:0]         ram_d_wstrb_o,
    input  logic [DATA_W-1:0]           ram_d_rdata_i
);

    localparam int ROM_AW = BOOTROM_ADDR_W - 2;
    localparam int RAM_AW = SRAM_ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = cnt_width(COPY_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COPY_WORDS - 1);

    if (COPY_WORDS < 1 || COPY_WORDS > 2 ** ROM_AW) begin : g_bad_copy_words
        $error("boot_copier: COPY_WORDS out of range for the boot ROM");
    end
    if (DEST_BASE < 0 || DEST_BASE + COPY_WORDS > 2 ** RAM_AW) begin : g_bad_dest_base
        $error("boot_copier: destination window does not fit in SRAM");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] rd_cnt;
    logic             rd_valid;
    logic             wr_pend;
    logic [CNT_W-1:0] wr_idx;

    logic                copy_valid;
    logic [RAM_AW-1:0]   copy_addr;
    logic [STRB_W-1:0]   copy_wstrb;

    // Two-stage pipeline: the read stage walks rd_cnt over the ROM, the write
    // stage (wr_pend/wr_idx) lags it by one edge to meet the ROM read latency.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            wr_pend  <= 1'b0;
            wr_idx   <= '0;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    state    <= COPY;
                    rd_cnt   <= '0;
                    rd_valid <= 1'b1;
                    wr_pend  <= 1'b0;
                    wr_idx   <= '0;
                end
                COPY: begin
                    if (rd_valid) begin
                        if (rd_cnt == LAST) begin
                            rd_valid <= 1'b0;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                    wr_pend <= rd_valid;
                    wr_idx  <= rd_cnt;
                    if (wr_pend && wr_idx == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        state    <= COPY;
                        rd_cnt   <= '0;
                        rd_valid <= 1'b1;
                        wr_pend  <= 1'b0;
                        wr_idx   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rst_o = (state != DONE);
    assign done_o    = (state == DONE);
    assign busy_o    = (state == COPY);

    // Gating the enables with cke keeps the ROM output register frozen during a stall.
    assign rom_r_valid_o = rd_valid & cke_i;
    assign rom_r_addr_o  = ROM_AW'(rd_cnt);

    assign copy_valid = wr_pend & cke_i;
    assign copy_addr  = wr_pend ? (RAM_AW'(DEST_BASE) + RAM_AW'(wr_idx)) : '0;
    assign copy_wstrb = {STRB_W{wr_pend}};

    iob_soc_opencryptolinux_dport_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (RAM_AW)
    ) u_dport_mux (
        .sel_cpu    (state == DONE),
        .copy_valid (copy_valid),
        .copy_addr  (copy_addr),
        .copy_wdata (rom_r_rdata_i),
        .copy_wstrb (copy_wstrb),
        .cpu_valid  (cpu_d_valid_i),
        .cpu_addr   (cpu_d_addr_i),
        .cpu_wdata  (cpu_d_wdata_i),
        .cpu_wstrb  (cpu_d_wstrb_i),
        .ram_valid  (ram_d_valid_o),
        .ram_addr   (ram_d_addr_o),
        .ram_wdata  (ram_d_wdata_o),
        .ram_wstrb  (ram_d_wstrb_o)
    );

    assign cpu_d_rdata_o = ram_d_rdata_i;

endmodule

// File: tb/tb_iob_soc_opencryptolinux_boot_copier.sv
// Bench for the boot copier: behavioural ROM/SRAM around the DUT, copy results
// and done timing predicted from word counts and cke-high edge counts.
module tb_iob_soc_opencryptolinux_boot_copier;

    localparam int DATA_W = 32;
    localparam int BA     = 12;
    localparam int SA     = 15;
    localparam int CW     = 4;
    localparam int DB     = 'h100;

    logic        clk = 1'b0;
    logic        cke, arst_n, start;
    logic        cpu_rst, done_o, busy_o;
    logic        rom_valid;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata;
    logic        cpu_valid;
    logic [12:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        ram_valid;
    logic [12:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;

    logic [31:0] rom_mem [0:1023];
    logic [31:0] sram    [0:8191];
    int          wr_cnt;
    logic [12:0] wr_log [$];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    iob_soc_opencryptolinux_boot_copier #(
        .DATA_W(DATA_W), .BOOTROM_ADDR_W(BA), .SRAM_ADDR_W(SA),
        .COPY_WORDS(CW), .DEST_BASE(DB)
    ) dut (
        .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .start_i(start),
        .cpu_rst_o(cpu_rst), .done_o(done_o), .busy_o(busy_o),
        .rom_r_valid_o(rom_valid), .rom_r_addr_o(rom_addr), .rom_r_rdata_i(rom_rdata),
        .cpu_d_valid_i(cpu_valid), .cpu_d_addr_i(cpu_addr), .cpu_d_wdata_i(cpu_wdata),
        .cpu_d_wstrb_i(cpu_wstrb), .cpu_d_rdata_o(cpu_rdata),
        .ram_d_valid_o(ram_valid), .ram_d_addr_o(ram_addr), .ram_d_wdata_o(ram_wdata),
        .ram_d_wstrb_o(ram_wstrb), .ram_d_rdata_i(ram_rdata)
    );

    // Registered-output boot ROM
    always @(posedge clk) begin
        if (rom_valid) rom_rdata <= rom_mem[rom_addr];
    end

    // Read-first byte-writable SRAM; also logs every write made while not done
    always @(posedge clk) begin
        if (ram_valid) begin
            ram_rdata <= sram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) sram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
            if (!done_o) begin
                wr_cnt = wr_cnt + 1;
                wr_log.push_back(ram_addr);
            end
        end
    end

    task automatic load_rom(input bit rnd);
        for (int i = 0; i < CW; i++) rom_mem[i] = rnd ? $urandom : 32'hA0 + i;
        for (int i = 0; i < CW; i++) sram[DB + i] = $urandom;
    endtask

    task automatic reset_release();
        @(posedge clk); #1;
        arst_n = 1'b0; cke = 1'b1; start = 1'b0;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        wr_cnt = 0;
        wr_log.delete();
    endtask

    task automatic run_to_done(output int edges);
        edges = 0;
        while (edges < 200 && !done_o) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic check_copy(input string tag);
        checks++;
        if (wr_cnt !== CW) $display("[TB] FAIL %s_write_count got %0d want %0d", tag, wr_cnt, CW);
        else passed++;
        for (int i = 0; i < CW; i++) begin
            checks++;
            if (sram[DB + i] !== rom_mem[i])
                $display("[TB] FAIL %s_sram[%0h] got %h want %h", tag, DB + i, sram[DB + i], rom_mem[i]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        arst_n = 1'b0; cke = 1'b1; start = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 13'h55; cpu_wdata = 32'h1; cpu_wstrb = 4'hF;
        #2;
        checks++;
        if ({cpu_rst, done_o, busy_o, rom_valid, rom_addr, ram_valid, ram_wstrb, ram_addr} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 4'd0, 13'd0})
            $display("[TB] FAIL reset_outputs got rst=%b done=%b busy=%b rv=%b ra=%h wv=%b ws=%h wa=%h want 1 0 0 0 0 0 0 0",
                     cpu_rst, done_o, busy_o, rom_valid, rom_addr, ram_valid, ram_wstrb, ram_addr);
        else passed++;
    endtask

    task automatic test_reset_copy();
        logic eb, ed, ew;
        load_rom(1'b0);
        reset_release();
        for (int k = 1; k <= CW + 3; k++) begin
            @(posedge clk); #1;
            eb = (k >= 1 && k <= CW + 1);
            ed = (k >= CW + 2);
            ew = (k >= 2 && k <= CW + 1);
            checks++;
            if ({busy_o, done_o, cpu_rst, ram_valid} !== {eb, ed, ~ed, ew})
                $display("[TB] FAIL copy_edge%0d got busy/done/rst/wr=%b%b%b%b want %b%b%b%b",
                         k, busy_o, done_o, cpu_rst, ram_valid, eb, ed, ~ed, ew);
            else passed++;
        end
        for (int i = 0; i < CW; i++) begin
            checks++;
            if (wr_log.size() <= i || wr_log[i] !== 13'(DB + i))
                $display("[TB] FAIL copy_addr_order idx %0d want %h", i, DB + i);
            else passed++;
        end
        check_copy("reset_copy");
    endtask

    task automatic test_cpu_passthrough();
        logic [31:0] old, merged;
        old = $urandom;
        sram['h10] = old;
        merged = {old[31:16], 16'hBEEF};
        cpu_valid = 1'b1; cpu_addr = 13'h10; cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'b0011;
        #1;
        checks++;
        if ({ram_valid, ram_addr, ram_wdata, ram_wstrb} !== {1'b1, 13'h10, 32'hDEADBEEF, 4'b0011})
            $display("[TB] FAIL passthrough got v=%b a=%h d=%h s=%b want 1 010 deadbeef 0011",
                     ram_valid, ram_addr, ram_wdata, ram_wstrb);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (sram['h10] !== merged) $display("[TB] FAIL cpu_partial_write got %h want %h", sram['h10], merged);
        else passed++;
        cpu_wstrb = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (cpu_rdata !== merged) $display("[TB] FAIL cpu_readback got %h want %h", cpu_rdata, merged);
        else passed++;
        cpu_valid = 1'b0;
    endtask

    task automatic test_restart();
        int edges;
        logic [31:0] junk;
        load_rom(1'b0);
        for (int i = 0; i < CW; i++) sram[DB + i] = rom_mem[i];
        cpu_valid = 1'b1; cpu_addr = 13'(DB + 1); cpu_wdata = 32'h12345678; cpu_wstrb = 4'hF;
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        checks++;
        if (sram[DB + 1] !== 32'h12345678) $display("[TB] FAIL cpu_overwrite got %h want 12345678", sram[DB + 1]);
        else passed++;
        start = 1'b1;
        wr_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({cpu_rst, done_o, busy_o} !== 3'b101)
            $display("[TB] FAIL restart_state got rst/done/busy=%b%b%b want 101", cpu_rst, done_o, busy_o);
        else passed++;
        junk = $urandom;
        sram['h20] = junk;
        cpu_valid = 1'b1; cpu_addr = 13'h20; cpu_wdata = ~junk; cpu_wstrb = 4'hF;
        run_to_done(edges);
        cpu_valid = 1'b0;
        checks++;
        if (edges !== CW + 1) $display("[TB] FAIL restart_latency got %0d want %0d", edges, CW + 1);
        else passed++;
        checks++;
        if (sram['h20] !== junk) $display("[TB] FAIL cpu_ignored_in_copy got %h want %h", sram['h20], junk);
        else passed++;
        check_copy("restart");
    endtask

    task automatic test_stall();
        int edges;
        bit bad;
        load_rom(1'b1);
        reset_release();
        edges = 0;
        bad = 1'b0;
        while (edges < 200 && !done_o) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 4) begin
                cke = 1'b0;
                repeat (3) begin
                    #3;
                    if (ram_valid !== 1'b0 || rom_valid !== 1'b0) bad = 1'b1;
                    @(posedge clk); #1;
                    edges++;
                end
                cke = 1'b1;
            end
        end
        checks++;
        if (bad) $display("[TB] FAIL stall_no_enables got enable high want low");
        else passed++;
        checks++;
        if (edges !== CW + 5) $display("[TB] FAIL stall_latency got %0d want %0d", edges, CW + 5);
        else passed++;
        check_copy("stall");
    endtask

    task automatic test_random_cke();
        int edges, hi;
        load_rom(1'b1);
        reset_release();
        edges = 0;
        hi = 0;
        while (edges < 200 && !done_o) begin
            cke = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            if (cke) hi++;
            #1;
            edges++;
        end
        cke = 1'b1;
        checks++;
        if (!done_o || hi !== CW + 2)
            $display("[TB] FAIL random_cke_latency got done=%b at %0d active edges want %0d", done_o, hi, CW + 2);
        else passed++;
        check_copy("random_cke");
    endtask

    task automatic test_reset_mid();
        int edges;
        load_rom(1'b0);
        reset_release();
        repeat (4) begin @(posedge clk); #1; end
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_rst, done_o, busy_o, rom_valid, ram_valid, ram_wstrb, ram_addr} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 13'd0})
            $display("[TB] FAIL mid_reset_outputs got rst=%b done=%b busy=%b rv=%b wv=%b ws=%h wa=%h",
                     cpu_rst, done_o, busy_o, rom_valid, ram_valid, ram_wstrb, ram_addr);
        else passed++;
        for (int i = 0; i < CW; i++) rom_mem[i] = $urandom;
        @(posedge clk); #1;
        arst_n = 1'b1;
        wr_cnt = 0;
        wr_log.delete();
        run_to_done(edges);
        checks++;
        if (edges !== CW + 2) $display("[TB] FAIL mid_reset_latency got %0d want %0d", edges, CW + 2);
        else passed++;
        checks++;
        if (wr_log.size() == 0 || wr_log[0] !== 13'(DB))
            $display("[TB] FAIL mid_reset_first_addr want %h", DB);
        else passed++;
        check_copy("mid_reset");
    endtask

    task automatic test_start_in_copy();
        int edges;
        load_rom(1'b1);
        reset_release();
        edges = 0;
        while (edges < 200 && !done_o) begin
            start = (edges + 1 == 2 || edges + 1 == 4);
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        checks++;
        if (edges !== CW + 2) $display("[TB] FAIL start_in_copy_latency got %0d want %0d", edges, CW + 2);
        else passed++;
        check_copy("start_in_copy");
    endtask

    initial begin
        cke = 1'b1; arst_n = 1'b0; start = 1'b0;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        wr_cnt = 0;
        test_reset();
        test_reset_copy();
        test_cpu_passthrough();
        test_restart();
        test_stall();
        test_random_cke();
        test_reset_mid();
        test_start_in_copy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
